// File: rtl/div_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : div_seq_pkg
// Brief    : Shared op codes, FSM states, flag bit positions and flag packer
//            for the multi-cycle divide sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package div_seq_pkg;

    localparam logic [1:0] DIV_UDIV = 2'b00;
    localparam logic [1:0] DIV_UREM = 2'b01;
    localparam logic [1:0] DIV_SDIV = 2'b10;
    localparam logic [1:0] DIV_SREM = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_RUN  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam int CIDX  = 0;
    localparam int VIDX  = 1;
    localparam int ZIDX  = 2;
    localparam int SIDX  = 3;
    localparam int PIDX  = 4;
    localparam int UIDX  = 5;
    localparam int N1IDX = 6;
    localparam int N2IDX = 7;

    // Result flags: Z/S/V come from the result, every other bit passes from fi.
    function automatic logic [7:0] make_flags(input logic [7:0] fi_in,
                                              input logic       z,
                                              input logic       s,
                                              input logic       v);
        logic [7:0] f;
        f       = fi_in;
        f[ZIDX] = z;
        f[SIDX] = s;
        f[VIDX] = v;
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_seq_adder.sv
`default_nettype none
// ============================================================================
// Module   : div_seq_adder
// Brief    : Ripple-style WIDTH-bit adder with carry in/out; used as the
//            trial subtractor of the divider (ci=1, bi=~divisor).
// Revision : 1.0 - initial release
// ============================================================================
module div_seq_adder #(
    parameter int WIDTH = 33
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] bi,
    input  logic             ci,
    output logic [WIDTH-1:0] sum,
    output logic             co
);

    assign {co, sum} = {1'b0, a} + {1'b0, bi} + {{WIDTH{1'b0}}, ci};

endmodule
`default_nettype wire

// File: rtl/div_seq.sv
`default_nettype none
// ============================================================================
// Module   : div_seq
// Brief    : Multi-cycle restoring divider (udiv/urem/sdiv/srem), one quotient
//            bit per cycle, with ALU-compatible res/fo/wb_en/flag_en outputs.
// Revision : 1.0 - initial release
// ============================================================================
module div_seq #(
    parameter int WIDTH = 32,
    parameter int CW    = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] di,
    input  logic [WIDTH-1:0] bi,
    input  logic [7:0]       fi,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res,
    output logic [7:0]       fo,
    output logic             wb_en,
    output logic             flag_en
);
    import div_seq_pkg::*;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [7:0]       r_fi;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_rem;
    logic [CW-1:0]    r_cnt;
    logic             r_qneg;
    logic             r_rneg;
    logic             r_ovf;
    logic [WIDTH-1:0] r_res;
    logic [7:0]       r_fo;

    logic             w_signed;
    logic             w_a_neg;
    logic             w_b_neg;
    logic             w_b_zero;
    logic             w_ovf;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic [WIDTH-1:0] w_dz_res;
    logic [WIDTH:0]   w_trial;
    logic             w_trial_ok;
    logic             w_unused_trial_msb;
    logic [WIDTH-1:0] w_quo;
    logic [WIDTH-1:0] w_rmd;
    logic [WIDTH-1:0] w_fix_res;

    assign w_signed = r_op[1];
    assign w_a_neg  = w_signed & r_a[WIDTH-1];
    assign w_b_neg  = w_signed & r_b[WIDTH-1];
    assign w_b_zero = (r_b == '0);
    assign w_mag_a  = w_a_neg ? -r_a : r_a;
    assign w_mag_b  = w_b_neg ? -r_b : r_b;
    assign w_ovf    = w_signed && (r_a == {1'b1, {(WIDTH-1){1'b0}}}) && (r_b == '1);
    // Divide by zero: quotient saturates to all ones, remainder is the raw dividend.
    assign w_dz_res = r_op[0] ? r_a : '1;

    // Trial = {rem, next dividend bit} - divisor; carry out means no borrow.
    div_seq_adder #(
        .WIDTH (WIDTH + 1)
    ) u_trial (
        .a   ({r_rem, r_dvd[WIDTH-1]}),
        .bi  (~{1'b0, r_dvs}),
        .ci  (1'b1),
        .sum (w_trial),
        .co  (w_trial_ok)
    );
    // A successful trial is always below the divisor, so its MSB is zero.
    assign w_unused_trial_msb = w_trial[WIDTH];

    assign w_quo     = r_qneg ? -r_dvd : r_dvd;
    assign w_rmd     = r_rneg ? -r_rem : r_rem;
    assign w_fix_res = r_op[0] ? w_rmd : w_quo;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: w_state_nxt = start ? S_PREP : S_IDLE;
            S_PREP:         w_state_nxt = w_b_zero ? S_DONE : S_RUN;
            S_RUN:          w_state_nxt = (r_cnt == CW'(1)) ? S_FIX : S_RUN;
            S_FIX:          w_state_nxt = S_DONE;
            default:        w_state_nxt = S_IDLE;
        endcase
        if (abort) begin
            w_state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_op   <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_fi   <= '0;
            r_dvd  <= '0;
            r_dvs  <= '0;
            r_rem  <= '0;
            r_cnt  <= '0;
            r_qneg <= 1'b0;
            r_rneg <= 1'b0;
            r_ovf  <= 1'b0;
            r_res  <= '0;
            r_fo   <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start && !abort) begin
                        r_op <= op;
                        r_a  <= di;
                        r_b  <= bi;
                        r_fi <= fi;
                    end
                end
                S_PREP: begin
                    r_dvd  <= w_mag_a;
                    r_dvs  <= w_mag_b;
                    r_rem  <= '0;
                    r_cnt  <= CW'(WIDTH);
                    r_qneg <= w_a_neg ^ w_b_neg;
                    r_rneg <= w_a_neg;
                    r_ovf  <= w_ovf;
                    if (w_b_zero && !abort) begin
                        r_res <= w_dz_res;
                        r_fo  <= make_flags(r_fi, (w_dz_res == '0), w_dz_res[WIDTH-1], 1'b1);
                    end
                end
                S_RUN: begin
                    if (w_trial_ok) begin
                        r_rem <= w_trial[WIDTH-1:0];
                    end else begin
                        r_rem <= {r_rem[WIDTH-2:0], r_dvd[WIDTH-1]};
                    end
                    r_dvd <= {r_dvd[WIDTH-2:0], w_trial_ok};
                    r_cnt <= r_cnt - CW'(1);
                end
                S_FIX: begin
                    if (!abort) begin
                        r_res <= w_fix_res;
                        r_fo  <= make_flags(r_fi, (w_fix_res == '0), w_fix_res[WIDTH-1], r_ovf);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy    = (r_state == S_PREP) || (r_state == S_RUN) || (r_state == S_FIX);
    assign done    = (r_state == S_DONE);
    assign wb_en   = (r_state == S_DONE);
    assign flag_en = (r_state == S_DONE);
    assign res     = r_res;
    assign fo      = r_fo;

endmodule
`default_nettype wire

// File: tb/tb_div_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_seq
// Brief    : Directed self-checking bench for the div_seq divide sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_seq;
    import div_seq_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] di;
    logic [31:0] bi;
    logic [7:0]  fi;
    logic        abort;
    logic        busy;
    logic        done;
    logic [31:0] res;
    logic [7:0]  fo;
    logic        wb_en;
    logic        flag_en;

    int passed;
    int total;

    div_seq #(.WIDTH(32), .CW(6)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .di      (di),
        .bi      (bi),
        .fi      (fi),
        .abort   (abort),
        .busy    (busy),
        .done    (done),
        .res     (res),
        .fo      (fo),
        .wb_en   (wb_en),
        .flag_en (flag_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a falling edge; the following rising edge is the start edge.
    task automatic issue(input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [7:0] f);
        start = 1'b1;
        op    = o;
        di    = a;
        bi    = b;
        fi    = f;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts rising edges from the start edge (which is edge 1) until done shows.
    task automatic wait_done(input int l0, output int lat);
        lat = l0;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        abort = 1'b0;
        op    = DIV_UDIV;
        di    = 32'd9;
        bi    = 32'd3;
        fi    = 8'hFF;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        total++;
        if ({busy, done, wb_en, flag_en} !== 4'b0000)
            $display("FAIL reset_ctrl: got %b expected 0000", {busy, done, wb_en, flag_en});
        else passed++;
        total++;
        if (res !== 32'd0 || fo !== 8'd0)
            $display("FAIL reset_data: got res=%h fo=%h expected 0/0", res, fo);
        else passed++;
        @(negedge clk);
        total++;
        if (busy !== 1'b0)
            $display("FAIL reset_idle: got busy=%b expected 0", busy);
        else passed++;
    endtask

    task automatic test_unsigned();
        int lat;
        issue(DIV_UDIV, 32'd100, 32'd7, 8'h06);
        total++;
        if (busy !== 1'b1) $display("FAIL udiv_busy: got %b expected 1", busy);
        else passed++;
        wait_done(1, lat);
        total++;
        if (lat !== 35) $display("FAIL udiv_latency: got %0d expected 35", lat);
        else passed++;
        total++;
        if (res !== 32'd14) $display("FAIL udiv_res: got %h expected %h", res, 32'd14);
        else passed++;
        total++;
        if (fo !== 8'h00) $display("FAIL udiv_flags: got %h expected 00", fo);
        else passed++;
        total++;
        if ({done, wb_en, flag_en, busy} !== 4'b1110)
            $display("FAIL udiv_done_ctrl: got %b expected 1110", {done, wb_en, flag_en, busy});
        else passed++;
        @(negedge clk);
        total++;
        if (done !== 1'b0 || wb_en !== 1'b0 || res !== 32'd14)
            $display("FAIL udiv_hold: got done=%b wb_en=%b res=%h expected 0/0/0000000e", done, wb_en, res);
        else passed++;

        issue(DIV_UREM, 32'd100, 32'd7, 8'h00);
        wait_done(1, lat);
        total++;
        if (lat !== 35 || res !== 32'd2)
            $display("FAIL urem: got lat=%0d res=%h expected 35/00000002", lat, res);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_signed();
        int lat;
        issue(DIV_SDIV, 32'hFFFFFF9C, 32'd7, 8'h00);
        wait_done(1, lat);
        total++;
        if (lat !== 35 || res !== 32'hFFFFFFF2 || fo !== 8'h08)
            $display("FAIL sdiv_neg_dvd: got lat=%0d res=%h fo=%h expected 35/fffffff2/08", lat, res, fo);
        else passed++;
        @(negedge clk);
        issue(DIV_SREM, 32'hFFFFFF9C, 32'd7, 8'h00);
        wait_done(1, lat);
        total++;
        if (res !== 32'hFFFFFFFE)
            $display("FAIL srem_neg_dvd: got %h expected fffffffe", res);
        else passed++;
        @(negedge clk);
        issue(DIV_SDIV, 32'd100, 32'hFFFFFFF9, 8'h00);
        wait_done(1, lat);
        total++;
        if (res !== 32'hFFFFFFF2)
            $display("FAIL sdiv_neg_dvs: got %h expected fffffff2", res);
        else passed++;
        @(negedge clk);
        issue(DIV_SREM, 32'd100, 32'hFFFFFFF9, 8'h00);
        wait_done(1, lat);
        total++;
        if (res !== 32'd2 || fo !== 8'h00)
            $display("FAIL srem_neg_dvs: got res=%h fo=%h expected 00000002/00", res, fo);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_div_zero();
        int lat;
        // fi = F7: C, V, Z and all pass-through bits set; Z/S/V must be recomputed.
        issue(DIV_UDIV, 32'd5, 32'd0, 8'hF7);
        wait_done(1, lat);
        total++;
        if (lat !== 2) $display("FAIL dz_latency: got %0d expected 2", lat);
        else passed++;
        total++;
        if (res !== 32'hFFFFFFFF || fo !== 8'hFB)
            $display("FAIL dz_udiv: got res=%h fo=%h expected ffffffff/fb", res, fo);
        else passed++;
        @(negedge clk);
        issue(DIV_UREM, 32'd5, 32'd0, 8'hF7);
        wait_done(1, lat);
        total++;
        if (lat !== 2 || res !== 32'd5 || fo !== 8'hF3)
            $display("FAIL dz_urem: got lat=%0d res=%h fo=%h expected 2/00000005/f3", lat, res, fo);
        else passed++;
        @(negedge clk);
        issue(DIV_SDIV, 32'hFFFFFF9C, 32'd0, 8'h00);
        wait_done(1, lat);
        total++;
        if (res !== 32'hFFFFFFFF || fo !== 8'h0A)
            $display("FAIL dz_sdiv: got res=%h fo=%h expected ffffffff/0a", res, fo);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_overflow();
        int lat;
        issue(DIV_SDIV, 32'h80000000, 32'hFFFFFFFF, 8'h00);
        wait_done(1, lat);
        total++;
        if (lat !== 35 || res !== 32'h80000000 || fo !== 8'h0A)
            $display("FAIL ovf_sdiv: got lat=%0d res=%h fo=%h expected 35/80000000/0a", lat, res, fo);
        else passed++;
        @(negedge clk);
        issue(DIV_SREM, 32'h80000000, 32'hFFFFFFFF, 8'h00);
        wait_done(1, lat);
        total++;
        if (res !== 32'd0 || fo !== 8'h06)
            $display("FAIL ovf_srem: got res=%h fo=%h expected 00000000/06", res, fo);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_abort();
        int lat;
        int seen;
        issue(DIV_UDIV, 32'd5, 32'd0, 8'hF7);
        wait_done(1, lat);
        @(negedge clk);
        issue(DIV_UDIV, 32'd1000, 32'd3, 8'h00);
        repeat (8) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        total++;
        if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL abort_stop: got busy=%b done=%b expected 0/0", busy, done);
        else passed++;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done || wb_en || flag_en) seen++;
            @(negedge clk);
        end
        total++;
        if (seen !== 0) $display("FAIL abort_no_done: got %0d done cycles expected 0", seen);
        else passed++;
        total++;
        if (res !== 32'hFFFFFFFF || fo !== 8'hFB)
            $display("FAIL abort_hold: got res=%h fo=%h expected ffffffff/fb", res, fo);
        else passed++;

        // abort beats a coincident start while idle
        start = 1'b1;
        abort = 1'b1;
        op    = DIV_UDIV;
        di    = 32'd7;
        bi    = 32'd1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        total++;
        if (busy !== 1'b0) $display("FAIL abort_start: got busy=%b expected 0", busy);
        else passed++;

        issue(DIV_UDIV, 32'd1000, 32'd3, 8'h00);
        wait_done(1, lat);
        total++;
        if (lat !== 35 || res !== 32'd333 || fo !== 8'h00)
            $display("FAIL abort_restart: got lat=%0d res=%h fo=%h expected 35/0000014d/00", lat, res, fo);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int lat;
        issue(DIV_UDIV, 32'd100, 32'd7, 8'h00);
        repeat (3) @(negedge clk);
        // start while busy must be ignored
        start = 1'b1;
        op    = DIV_UREM;
        di    = 32'd1;
        bi    = 32'd1;
        @(negedge clk);
        start = 1'b0;
        wait_done(5, lat);
        total++;
        if (lat !== 35 || res !== 32'd14)
            $display("FAIL b2b_busy_start: got lat=%0d res=%h expected 35/0000000e", lat, res);
        else passed++;
        total++;
        if (busy !== 1'b0) $display("FAIL b2b_done_busy: got %b expected 0", busy);
        else passed++;
        issue(DIV_UDIV, 32'd9, 32'd3, 8'h00);
        total++;
        if (busy !== 1'b1 || done !== 1'b0)
            $display("FAIL b2b_accept: got busy=%b done=%b expected 1/0", busy, done);
        else passed++;
        wait_done(1, lat);
        total++;
        if (lat !== 35 || res !== 32'd3 || wb_en !== 1'b1)
            $display("FAIL b2b_second: got lat=%0d res=%h wb_en=%b expected 35/00000003/1", lat, res, wb_en);
        else passed++;
        @(negedge clk);
    endtask

    initial begin
        passed = 0;
        total  = 0;
        reset  = 1'b1;
        start  = 1'b0;
        abort  = 1'b0;
        op     = 2'b00;
        di     = '0;
        bi     = '0;
        fi     = '0;
        @(negedge clk);
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_abort();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
